// File: rtl/mem_ctrl_arbiter.sv
// Arbitrates icache/dcache block requests onto one main-memory port with a single outstanding transaction.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise the icache has fixed priority.

package mem_ctrl_arbiter_pkg;
  typedef logic [25:0]  main_mem_block_addr_t;
  typedef logic [127:0] block_data_t;
  typedef enum logic { REQ_READ = 1'b0, REQ_WRITE = 1'b1 } req_type_t;
endpackage

module mem_ctrl_arbiter
  import mem_ctrl_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_aL,
  input  logic                 icache_req_valid,
  input  main_mem_block_addr_t icache_req_block_addr,
  output logic                 icache_req_ready,
  output logic                 icache_resp_valid,
  output block_data_t          icache_resp_block_data,
  input  logic                 dcache_req_valid,
  input  req_type_t            dcache_req_type,
  input  main_mem_block_addr_t dcache_req_block_addr,
  input  block_data_t          dcache_req_block_data,
  output logic                 dcache_req_ready,
  output logic                 dcache_resp_valid,
  output block_data_t          dcache_resp_block_data,
  output logic                 mem_req_valid,
  output req_type_t            mem_req_type,
  output main_mem_block_addr_t mem_req_block_addr,
  output block_data_t          mem_req_block_data,
  input  logic                 mem_req_ready,
  input  logic                 mem_resp_valid,
  input  block_data_t          mem_resp_block_data,
  output logic                 timeout_err
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(MAX_OUTSTANDING_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_SAT  = 8'(MAX_OUTSTANDING_CYCLES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_ownerDcache;
  logic [7:0]           r_cycleCount;
  logic                 r_memReqValid;
  req_type_t            r_memReqType;
  main_mem_block_addr_t r_memReqAddr;
  block_data_t          r_memReqData;
  logic                 r_timeoutErr;

  logic w_anyValid;
  logic w_grant;
  logic w_grantDcache;
  logic w_respHit;
  logic w_waitIcache;
  logic w_waitDcache;

  assign w_anyValid = icache_req_valid | dcache_req_valid;
  // Gated by rst_aL so the ready outputs stay low while reset is held.
  assign w_grant    = rst_aL & (r_state == IDLE) & w_anyValid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_lastDcache;

  assign w_grantDcache = (icache_req_valid & dcache_req_valid) ? ~r_lastDcache : dcache_req_valid;

  // Pointer starts at dcache so the first contention after reset goes to the icache.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_lastDcache <= 1'b1;
    end else if (w_grant) begin
      r_lastDcache <= w_grantDcache;
    end
  end
`else
  assign w_grantDcache = ~icache_req_valid;
`endif

  assign icache_req_ready = w_grant & ~w_grantDcache;
  assign dcache_req_ready = w_grant & w_grantDcache;

  assign w_waitIcache = (r_state == WAIT_RESP) & ~r_ownerDcache;
  assign w_waitDcache = (r_state == WAIT_RESP) & r_ownerDcache;
  assign w_respHit    = (r_state == WAIT_RESP) & mem_resp_valid;

  assign icache_resp_valid      = w_respHit & ~r_ownerDcache;
  assign dcache_resp_valid      = w_respHit & r_ownerDcache;
  assign icache_resp_block_data = w_waitIcache ? mem_resp_block_data : '0;
  assign dcache_resp_block_data = w_waitDcache ? mem_resp_block_data : '0;

  assign mem_req_valid      = r_memReqValid;
  assign mem_req_type       = r_memReqType;
  assign mem_req_block_addr = r_memReqAddr;
  assign mem_req_block_data = r_memReqData;
  assign timeout_err        = r_timeoutErr;

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_state       <= IDLE;
      r_ownerDcache <= 1'b0;
      r_cycleCount  <= 8'd0;
      r_memReqValid <= 1'b0;
      r_memReqType  <= REQ_READ;
      r_memReqAddr  <= '0;
      r_memReqData  <= '0;
      r_timeoutErr  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_ownerDcache <= w_grantDcache;
            r_memReqType  <= w_grantDcache ? dcache_req_type : REQ_READ;
            r_memReqAddr  <= w_grantDcache ? dcache_req_block_addr : icache_req_block_addr;
            r_memReqData  <= w_grantDcache ? dcache_req_block_data : '0;
            r_memReqValid <= 1'b1;
            r_state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            r_memReqValid <= 1'b0;
            r_cycleCount  <= 8'd0;
            r_state       <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          // A response arriving on the last allowed cycle still wins over the timeout.
          if (mem_resp_valid) begin
            r_state <= IDLE;
          end else if (r_cycleCount >= TIMEOUT_LAST) begin
            r_cycleCount <= TIMEOUT_SAT;
            r_timeoutErr <= 1'b1;
            r_state      <= IDLE;
          end else begin
            r_cycleCount <= r_cycleCount + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
